// File: rtl/multicore_pkg.sv
// ---------------------------------------------------------------------------
// multicore_pkg
// Shared definitions for the multicore input feeder and output collector.
// Holds the core-array dimensions, the idle request code and the FSM
// state encoding, so both sides of the core array agree on them.
// No ports (package).
// ---------------------------------------------------------------------------
package multicore_pkg;

    localparam int N_CORES     = 27;
    localparam int DATA_W      = 19;
    localparam int REQ_W       = 4;
    localparam int IO_OUT_W    = 28;
    localparam int RST_STAGGER = 15;

    // A core with this request code is not asking for anything.
    localparam logic [REQ_W-1:0] REQ_IDLE = '0;

    typedef logic [1:0] feeder_state_t;

    localparam feeder_state_t ST_IDLE  = 2'd0;
    localparam feeder_state_t ST_ISSUE = 2'd1;
    localparam feeder_state_t ST_COOL  = 2'd2;

endpackage

// File: rtl/multicore_rr_arb.sv
// ---------------------------------------------------------------------------
// multicore_rr_arb
// Combinational round-robin pick: returns the first asserted request at or
// above rr_ptr, wrapping past N-1 back to 0.
// Ports:
//   req_valid  in   N        qualified requests
//   rr_ptr     in   IDX_W    search start, always < N
//   any        out  1        at least one request asserted
//   idx        out  IDX_W    index of the picked request (0 when none)
// ---------------------------------------------------------------------------
module multicore_rr_arb #(
    parameter int N     = 27,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req_valid,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    // rr_ptr never exceeds N-1, so a single conditional subtract is enough
    // to fold the candidate index back into range without a divider.
    always_comb begin : pick
        int cand;
        any  = 1'b0;
        idx  = '0;
        cand = 0;
        for (int k = 0; k < N; k++) begin
            cand = int'(rr_ptr) + k;
            if (cand >= N) cand = cand - N;
            if (!any && req_valid[cand]) begin
                any = 1'b1;
                idx = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/multicore_in_feeder.sv
// ---------------------------------------------------------------------------
// multicore_in_feeder
// Buffers the upstream sample stream in a small FIFO and hands samples one
// at a time to the rede_taylor cores that request them, choosing between
// cores round-robin. Each sample goes to exactly one core.
// Ports:
//   clk       in   1               clock, posedge
//   rst       in   1               synchronous active-high reset
//   s_valid   in   1               upstream sample valid
//   s_data    in   DATA_W          upstream sample (signed)
//   s_ready   out  1               FIFO not full
//   req_flat  in   N_CORES*REQ_W   per-core request codes, 0 = idle
//   io_in     out  DATA_W          sample bus shared by all cores
//   io_grant  out  N_CORES         one-hot grant, valid for one cycle
//   io_tag    out  REQ_W           request code of the granted core
//   ovf       out  1               sticky: push attempted while full
//   n_served  out  CNT_W           samples delivered since reset (wraps)
// ---------------------------------------------------------------------------
module multicore_in_feeder
    import multicore_pkg::*;
#(
    parameter int N_CORES    = multicore_pkg::N_CORES,
    parameter int DATA_W     = multicore_pkg::DATA_W,
    parameter int REQ_W      = multicore_pkg::REQ_W,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      s_valid,
    input  logic signed [DATA_W-1:0]  s_data,
    output logic                      s_ready,
    input  logic [N_CORES*REQ_W-1:0]  req_flat,
    output logic signed [DATA_W-1:0]  io_in,
    output logic [N_CORES-1:0]        io_grant,
    output logic [REQ_W-1:0]          io_tag,
    output logic                      ovf,
    output logic [CNT_W-1:0]          n_served
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int IDX_W = $clog2(N_CORES);

    logic signed [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW:0]              wr_ptr;
    logic [AW:0]              rd_ptr;
    logic                     full;
    logic                     empty;
    logic                     push;
    logic                     pop;
    logic signed [DATA_W-1:0] head;

    feeder_state_t            state;
    logic [IDX_W-1:0]         rr_ptr;
    logic [IDX_W-1:0]         win_idx;
    logic [N_CORES-1:0]       mask;
    logic [N_CORES-1:0]       mask_next;
    logic [N_CORES-1:0]       req_valid;
    logic                     arb_any;
    logic [IDX_W-1:0]         arb_idx;
    logic [REQ_W-1:0]         arb_code;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign s_ready = !full;
    assign push    = s_valid && !full;
    assign pop     = (state == ST_ISSUE);
    assign head    = mem[rd_ptr[AW-1:0]];
    assign arb_code = req_flat[arb_idx*REQ_W +: REQ_W];

    // A core is eligible when it shows a non-idle code and has not just been
    // served while still holding that same request. The mask bit is dropped
    // as soon as the core's code reads idle; the winner is only masked when
    // it is still requesting at grant time.
    always_comb begin
        req_valid = '0;
        mask_next = mask;
        for (int i = 0; i < N_CORES; i++) begin
            req_valid[i] = (req_flat[i*REQ_W +: REQ_W] != '0) && !mask[i];
            if (req_flat[i*REQ_W +: REQ_W] == '0) mask_next[i] = 1'b0;
        end
        if (state == ST_ISSUE)
            mask_next[win_idx] = (req_flat[win_idx*REQ_W +: REQ_W] != '0);
    end

    multicore_rr_arb #(
        .N     (N_CORES),
        .IDX_W (IDX_W)
    ) u_arb (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr),
        .any       (arb_any),
        .idx       (arb_idx)
    );

    // Sample storage needs no reset: emptiness is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= s_data;
    end

    // FIFO pointers, overflow flag, arbitration FSM and the output bus.
    // The grant, tag and sample are loaded together on the IDLE->ISSUE edge
    // so they are stable for the whole ISSUE cycle; io_in and io_tag then
    // simply hold until the next grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ovf      <= 1'b0;
            state    <= ST_IDLE;
            rr_ptr   <= '0;
            win_idx  <= '0;
            mask     <= '0;
            io_in    <= '0;
            io_grant <= '0;
            io_tag   <= '0;
            n_served <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (s_valid && full) ovf <= 1'b1;
            mask <= mask_next;

            case (state)
                ST_IDLE: begin
                    if (!empty && arb_any) begin
                        win_idx  <= arb_idx;
                        io_in    <= head;
                        io_tag   <= arb_code;
                        io_grant <= {{(N_CORES-1){1'b0}}, 1'b1} << arb_idx;
                        state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    n_served <= n_served + 1'b1;
                    rr_ptr   <= (win_idx == IDX_W'(N_CORES-1)) ? '0 : win_idx + 1'b1;
                    io_grant <= '0;
                    state    <= ST_COOL;
                end
                ST_COOL: begin
                    state <= ST_IDLE;
                end
                default: begin
                    io_grant <= '0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicore_in_feeder.sv
// ---------------------------------------------------------------------------
// tb_multicore_in_feeder
// Self-checking bench for multicore_in_feeder. Keeps a queue of accepted
// samples, a round-robin start index and a per-core "already served while
// holding" flag, and predicts every grant from those.
// ---------------------------------------------------------------------------
module tb_multicore_in_feeder;

    localparam int NC = 27;
    localparam int DW = 19;
    localparam int RW = 4;
    localparam int FD = 16;
    localparam int CW = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              s_valid;
    logic [DW-1:0]     s_data;
    logic              s_ready;
    logic [NC*RW-1:0]  req_flat;
    logic [DW-1:0]     io_in;
    logic [NC-1:0]     io_grant;
    logic [RW-1:0]     io_tag;
    logic              ovf;
    logic [CW-1:0]     n_served;

    logic [RW-1:0]     req_code [NC];

    // reference model state
    logic [DW-1:0]     m_q [$];
    int                m_rr;
    int                m_served;
    bit                m_ovf;
    bit                m_blocked [NC];
    int                last_grant;

    int                total = 0;
    int                bad   = 0;
    int                cyc   = 0;

    multicore_in_feeder dut (
        .clk      (clk),
        .rst      (rst),
        .s_valid  (s_valid),
        .s_data   (s_data),
        .s_ready  (s_ready),
        .req_flat (req_flat),
        .io_in    (io_in),
        .io_grant (io_grant),
        .io_tag   (io_tag),
        .ovf      (ovf),
        .n_served (n_served)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        req_flat = '0;
        for (int i = 0; i < NC; i++) req_flat[i*RW +: RW] = req_code[i];
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic setReq(input int core, input logic [RW-1:0] code);
        req_code[core] = code;
        if (code == '0) m_blocked[core] = 1'b0;
    endtask

    task automatic modelReset();
        m_q.delete();
        m_rr       = 0;
        m_served   = 0;
        m_ovf      = 1'b0;
        last_grant = -1;
        for (int i = 0; i < NC; i++) m_blocked[i] = 1'b0;
    endtask

    task automatic doReset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        modelReset();
    endtask

    // One upstream push attempt; the FIFO takes it only while it has room.
    task automatic applyStimulus(input logic [DW-1:0] data);
        checkOutput("s_ready", s_ready, m_q.size() < FD);
        s_valid = 1'b1;
        s_data  = data;
        if (m_q.size() < FD) m_q.push_back(data);
        else m_ovf = 1'b1;
        tick();
        s_valid = 1'b0;
    endtask

    function automatic int modelPick();
        int c;
        for (int k = 0; k < NC; k++) begin
            c = (m_rr + k) % NC;
            if (req_code[c] != '0 && !m_blocked[c]) return c;
        end
        return -1;
    endfunction

    task automatic waitGrant(input int budget, output int idx, output bit seen);
        idx  = -1;
        seen = 1'b0;
        repeat (budget) begin
            tick();
            if (io_grant != '0) begin
                seen = 1'b1;
                break;
            end
        end
        if (seen)
            for (int i = 0; i < NC; i++) if (io_grant[i]) idx = i;
    endtask

    // Expects one grant within budget cycles, checks it against the model,
    // then checks the following cycle (grant gone, bus held, count bumped).
    // Returns at the negedge of the cycle after the grant.
    task automatic serveOne(input string tag, input int budget, output int idx);
        int            exp_idx;
        bit            seen;
        logic [DW-1:0] held;
        waitGrant(budget, idx, seen);
        checkOutput({tag, "_seen"}, seen, 1'b1);
        if (seen) begin
            exp_idx = modelPick();
            checkOutput({tag, "_onehot"}, $onehot(io_grant), 1'b1);
            checkOutput({tag, "_idx"}, idx, exp_idx);
            if (exp_idx >= 0) checkOutput({tag, "_tag"}, io_tag, req_code[exp_idx]);
            if (m_q.size() > 0) checkOutput({tag, "_data"}, io_in, m_q[0]);
            if (last_grant >= 0) checkOutput({tag, "_gap"}, (cyc - last_grant) >= 3, 1'b1);
            last_grant = cyc;
            if (m_q.size() > 0) void'(m_q.pop_front());
            m_served++;
            if (exp_idx >= 0) begin
                m_rr = (exp_idx + 1) % NC;
                if (req_code[exp_idx] != '0) m_blocked[exp_idx] = 1'b1;
            end
            held = io_in;
            tick();
            checkOutput({tag, "_grant_off"}, io_grant, '0);
            checkOutput({tag, "_io_hold"}, io_in, held);
            checkOutput({tag, "_n_served"}, n_served, CW'(m_served));
        end
    endtask

    initial begin : stimulus
        int   idx;
        bit   seen;
        int   ord [6];
        int   cs [4];
        int   n;
        int   grants;
        bit   dup;

        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        for (int i = 0; i < NC; i++) req_code[i] = '0;
        modelReset();
        repeat (3) tick();
        rst = 1'b0;

        $display("[TB] reset and idle");
        checkOutput("rst_io_in", io_in, '0);
        checkOutput("rst_io_tag", io_tag, '0);
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput("idle_grant", io_grant, '0);
            checkOutput("idle_s_ready", s_ready, 1'b1);
            checkOutput("idle_n_served", n_served, '0);
            checkOutput("idle_ovf", ovf, 1'b0);
        end

        $display("[TB] single sample to core 3");
        applyStimulus(DW'(5));
        setReq(3, 4'h2);
        serveOne("single", 1, idx);
        checkOutput("single_grant_bits", idx, 3);
        checkOutput("single_n_served", n_served, 1);
        setReq(3, '0);
        tick();
        setReq(3, 4'h1);
        waitGrant(6, idx, seen);
        checkOutput("empty_no_grant", seen, 1'b0);
        setReq(3, '0);
        tick();

        $display("[TB] round robin over cores 0, 5, 26");
        doReset();
        for (int i = 0; i < 6; i++) applyStimulus(DW'($urandom));
        setReq(0,  RW'($urandom_range(1, 15)));
        setReq(5,  RW'($urandom_range(1, 15)));
        setReq(26, RW'($urandom_range(1, 15)));
        ord = '{0, 5, 26, 0, 5, 26};
        for (int g = 0; g < 6; g++) begin
            serveOne("rr", 3, idx);
            checkOutput("rr_order", idx, ord[g]);
            if (idx >= 0) begin
                setReq(idx, '0);
                tick();
                setReq(idx, RW'($urandom_range(1, 15)));
            end
        end
        setReq(0, '0);
        setReq(5, '0);
        setReq(26, '0);
        tick();

        $display("[TB] pointer wrap after core 26");
        applyStimulus(DW'($urandom));
        applyStimulus(DW'($urandom));
        setReq(26, RW'($urandom_range(1, 15)));
        serveOne("wrap26", 3, idx);
        checkOutput("wrap_first", idx, 26);
        setReq(26, '0);
        tick();
        setReq(0,  RW'($urandom_range(1, 15)));
        setReq(25, RW'($urandom_range(1, 15)));
        serveOne("wrap0", 3, idx);
        checkOutput("wrap_next", idx, 0);
        setReq(0, '0);
        setReq(25, '0);
        tick();

        $display("[TB] random core subset");
        for (int i = 0; i < 4; i++) begin
            do begin
                cs[i] = $urandom_range(0, NC - 1);
                dup = 1'b0;
                for (int j = 0; j < i; j++) if (cs[j] == cs[i]) dup = 1'b1;
            end while (dup);
        end
        n = $urandom_range(3, 10);
        for (int i = 0; i < n; i++) applyStimulus(DW'($urandom));
        for (int i = 0; i < 4; i++) setReq(cs[i], RW'($urandom_range(1, 15)));
        for (int g = 0; g < n; g++) begin
            serveOne("rand", 3, idx);
            if (idx >= 0) begin
                setReq(idx, '0);
                tick();
                setReq(idx, RW'($urandom_range(1, 15)));
            end
        end
        for (int i = 0; i < 4; i++) setReq(cs[i], '0);
        tick();

        $display("[TB] held request is not served twice");
        applyStimulus(DW'($urandom));
        applyStimulus(DW'($urandom));
        setReq(9, 4'h7);
        serveOne("held", 3, idx);
        checkOutput("held_idx", idx, 9);
        waitGrant(8, idx, seen);
        checkOutput("held_no_regrant", seen, 1'b0);
        setReq(9, '0);
        tick();
        setReq(9, 4'h5);
        serveOne("held_again", 3, idx);
        checkOutput("held_again_idx", idx, 9);
        setReq(9, '0);
        tick();

        $display("[TB] overflow with 17 pushes");
        for (int i = 0; i < 17; i++) applyStimulus(DW'($urandom));
        checkOutput("full_s_ready", s_ready, 1'b0);
        checkOutput("full_ovf", ovf, m_ovf);
        grants = 0;
        for (int g = 0; g < 16; g++) begin
            setReq(12, RW'($urandom_range(1, 15)));
            serveOne("drain", 3, idx);
            if (idx == 12) grants++;
            setReq(12, '0);
            tick();
        end
        setReq(12, 4'h3);
        waitGrant(8, idx, seen);
        checkOutput("drain_no_17th", seen, 1'b0);
        checkOutput("drain_count", grants, 16);
        checkOutput("drain_ovf_sticky", ovf, 1'b1);
        checkOutput("drain_s_ready", s_ready, 1'b1);
        setReq(12, '0);
        tick();

        $display("[TB] reset during ISSUE");
        applyStimulus(DW'($urandom));
        setReq(7, 4'h3);
        waitGrant(3, idx, seen);
        checkOutput("rst_issue_seen", seen, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        modelReset();
        checkOutput("rst_issue_grant", io_grant, '0);
        checkOutput("rst_issue_n_served", n_served, '0);
        checkOutput("rst_issue_s_ready", s_ready, 1'b1);
        checkOutput("rst_issue_ovf", ovf, 1'b0);
        waitGrant(6, idx, seen);
        checkOutput("rst_fifo_empty", seen, 1'b0);
        applyStimulus(DW'($urandom));
        serveOne("post_rst", 3, idx);
        checkOutput("post_rst_idx", idx, 7);
        setReq(7, '0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
